// File: rtl/id_hazard_ctrl_pkg.sv
// Shared opcode definitions plus IF/ID control types and operand-use helpers.
package id_hazard_ctrl_pkg;

  typedef enum logic [5:0] {
    OP_NOP,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
    OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_FENCE, OP_ECALL, OP_EBREAK
  } opcode_out_t;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } ctrl_state_t;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // True when the instruction reads rs1.
  function automatic logic uses_rs1(input opcode_out_t op);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_ECALL, OP_EBREAK, OP_NOP: return 1'b0;
      default:                                              return 1'b1;
    endcase
  endfunction

  // True when the instruction reads rs2 (R-type, stores, branches).
  function automatic logic uses_rs2(input opcode_out_t op);
    case (op)
      OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
      OP_SRL, OP_SRA, OP_OR, OP_AND,
      OP_SB, OP_SH, OP_SW,
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: return 1'b1;
      default:                                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/id_hazard_ctrl.sv
// IF/ID pipeline register, load-use stall detection and ECALL/EBREAK halt sequencing.
//
// state  | meaning
// RUN    | normal flow: redirect kill, load-use stall, halt entry or advance
// DRAIN  | halt instruction has left ID; older instructions retire, fetch held
// HALTED | core stopped; waits for a resume pulse
module id_hazard_ctrl
  import id_hazard_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 16,
  parameter logic [31:0] NOP_INSTR    = id_hazard_ctrl_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  input  logic [31:0]       if_instr,
  input  logic [31:0]       if_pc,
  input  opcode_out_t       id_opcode,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              ex_is_load,
  input  logic [4:0]        ex_rd,
  input  logic              ex_redirect,
  input  logic              resume,
  output logic              ifid_valid,
  output logic [31:0]       ifid_instr,
  output logic [31:0]       ifid_pc,
  output logic              pc_stall,
  output logic              id_bubble,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_count
);

  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  ctrl_state_t      state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic             ifid_valid_d;
  logic [31:0]      ifid_instr_d;
  logic [31:0]      ifid_pc_d;
  logic [CNT_W-1:0] stall_count_d;
  logic             lu;
  logic             halt_op;

  // Load-use hazard and halt-instruction detection on the registered IF/ID contents.
  always_comb begin
    lu = ifid_valid && ex_is_load && (ex_rd != 5'd0) &&
         ((uses_rs1(id_opcode) && (ex_rd == id_rs1)) ||
          (uses_rs2(id_opcode) && (ex_rd == id_rs2)));
    halt_op = ifid_valid && ((id_opcode == OP_ECALL) || (id_opcode == OP_EBREAK));
  end

  // Next-state, IF/ID update and stall/bubble outputs.
  always_comb begin
    state_d       = state_q;
    drain_d       = drain_q;
    ifid_valid_d  = ifid_valid;
    ifid_instr_d  = ifid_instr;
    ifid_pc_d     = ifid_pc;
    stall_count_d = stall_count;
    pc_stall      = 1'b0;
    id_bubble     = 1'b0;
    case (state_q)
      RUN: begin
        if (ex_redirect) begin
          id_bubble    = 1'b1;
          ifid_valid_d = 1'b0;
          ifid_instr_d = NOP_INSTR;
        end else if (lu) begin
          pc_stall  = 1'b1;
          id_bubble = 1'b1;
          if (stall_count != {CNT_W{1'b1}}) begin
            stall_count_d = stall_count + 1'b1;
          end
        end else if (halt_op) begin
          // The halt instruction itself still goes down the pipe.
          pc_stall     = 1'b1;
          state_d      = DRAIN;
          drain_d      = DRAIN_LOAD;
          ifid_valid_d = 1'b0;
          ifid_instr_d = NOP_INSTR;
        end else begin
          ifid_valid_d = if_valid;
          ifid_instr_d = if_valid ? if_instr : NOP_INSTR;
          ifid_pc_d    = if_pc;
        end
      end
      DRAIN: begin
        pc_stall  = 1'b1;
        id_bubble = 1'b1;
        if (drain_q == '0) begin
          state_d = HALTED;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      HALTED: begin
        pc_stall  = 1'b1;
        id_bubble = 1'b1;
        if (resume) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State, IF/ID and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      drain_q     <= '0;
      ifid_valid  <= 1'b0;
      ifid_instr  <= NOP_INSTR;
      ifid_pc     <= 32'd0;
      stall_count <= '0;
      halted      <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      ifid_valid  <= ifid_valid_d;
      ifid_instr  <= ifid_instr_d;
      ifid_pc     <= ifid_pc_d;
      stall_count <= stall_count_d;
      halted      <= (state_d == HALTED);
    end
  end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl with a cycle-level reference model.
module tb_id_hazard_ctrl;
  import id_hazard_ctrl_pkg::*;

  localparam int DRAIN = 3;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;
  localparam logic [31:0] NOPW = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_valid;
  logic [31:0]   if_instr;
  logic [31:0]   if_pc;
  opcode_out_t   id_opcode;
  logic [4:0]    id_rs1, id_rs2;
  logic          ex_is_load;
  logic [4:0]    ex_rd;
  logic          ex_redirect;
  logic          resume;
  logic          ifid_valid;
  logic [31:0]   ifid_instr, ifid_pc;
  logic          pc_stall, id_bubble, halted;
  logic [CW-1:0] stall_count;

  int n_cmp  = 0;
  int n_fail = 0;

  id_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(CW), .NOP_INSTR(NOPW)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_is_load(ex_is_load),
    .ex_rd(ex_rd), .ex_redirect(ex_redirect), .resume(resume), .ifid_valid(ifid_valid),
    .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .pc_stall(pc_stall), .id_bubble(id_bubble),
    .halted(halted), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: mode 0 running, 1 draining, 2 halted.
  int          m_mode;
  int          m_left;
  bit          m_v;
  logic [31:0] m_instr, m_pc;
  int          m_cnt;
  bit          chk_en = 1'b0;

  function automatic bit reads_rs1(input opcode_out_t op);
    return !(op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_ECALL, OP_EBREAK, OP_NOP});
  endfunction

  function automatic bit reads_rs2(input opcode_out_t op);
    return op inside {OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
                      OP_OR, OP_AND, OP_SB, OP_SH, OP_SW,
                      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
  endfunction

  function automatic bit model_lu();
    return m_v && ex_is_load && (ex_rd != 0) &&
           ((reads_rs1(id_opcode) && ex_rd == id_rs1) || (reads_rs2(id_opcode) && ex_rd == id_rs2));
  endfunction

  function automatic bit model_halt_op();
    return m_v && (id_opcode == OP_ECALL || id_opcode == OP_EBREAK);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_mode = 0; m_left = 0; m_v = 0; m_instr = NOPW; m_pc = 0; m_cnt = 0;
      chk_en = 1'b1;
    end else if (m_mode == 0) begin
      if (ex_redirect) begin
        m_v = 0; m_instr = NOPW;
      end else if (model_lu()) begin
        if (m_cnt < CMAX) m_cnt = m_cnt + 1;
      end else if (model_halt_op()) begin
        m_mode = 1; m_left = DRAIN; m_v = 0; m_instr = NOPW;
      end else begin
        m_v = if_valid; m_instr = if_valid ? if_instr : NOPW; m_pc = if_pc;
      end
    end else if (m_mode == 1) begin
      m_left = m_left - 1;
      if (m_left == 0) m_mode = 2;
    end else if (resume) begin
      m_mode = 0;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      bit e_stall, e_bub;
      if (m_mode != 0) begin
        e_stall = 1; e_bub = 1;
      end else if (ex_redirect) begin
        e_stall = 0; e_bub = 1;
      end else if (model_lu()) begin
        e_stall = 1; e_bub = 1;
      end else if (model_halt_op()) begin
        e_stall = 1; e_bub = 0;
      end else begin
        e_stall = 0; e_bub = 0;
      end
      check("pc_stall", 32'(pc_stall), 32'(e_stall));
      check("id_bubble", 32'(id_bubble), 32'(e_bub));
      check("ifid_valid", 32'(ifid_valid), 32'(m_v));
      check("ifid_instr", ifid_instr, m_instr);
      if (m_v) check("ifid_pc", ifid_pc, m_pc);
      check("halted", 32'(halted), 32'(m_mode == 2));
      check("stall_count", 32'(stall_count), 32'(m_cnt));
    end
  end

  task automatic step(input bit fv, input logic [31:0] fi, input logic [31:0] fp,
                      input opcode_out_t op, input logic [4:0] r1, input logic [4:0] r2,
                      input bit ld, input logic [4:0] rd, input bit rdr, input bit res);
    @(negedge clk);
    if_valid = fv; if_instr = fi; if_pc = fp;
    id_opcode = op; id_rs1 = r1; id_rs2 = r2;
    ex_is_load = ld; ex_rd = rd; ex_redirect = rdr; resume = res;
  endtask

  task automatic idle();
    step(0, 32'h0, 32'h0, OP_NOP, 0, 0, 0, 0, 0, 0);
  endtask

  int  ns;
  bit  saw_halt;

  initial begin
    rst_n = 0; if_valid = 0; if_instr = 0; if_pc = 0; id_opcode = OP_NOP;
    id_rs1 = 0; id_rs2 = 0; ex_is_load = 0; ex_rd = 0; ex_redirect = 0; resume = 0;
    idle(); idle();
    rst_n = 1;
    idle(); #3;
    check("rst_ifid_valid", 32'(ifid_valid), 32'd0);
    check("rst_ifid_instr", ifid_instr, 32'h13);
    check("rst_count", 32'(stall_count), 32'd0);
    check("rst_pc_stall", 32'(pc_stall), 32'd0);

    // load-use on rs2 of an ADD
    step(1, 32'h0002_A283, 32'h100, OP_NOP, 0, 0, 0, 0, 0, 0);
    step(1, 32'h0050_8333, 32'h104, OP_LW, 2, 0, 0, 0, 0, 0);
    step(1, 32'h0000_0393, 32'h108, OP_ADD, 1, 5, 1, 5, 0, 0); #3;
    check("lu_pc_stall", 32'(pc_stall), 32'd1);
    check("lu_bubble", 32'(id_bubble), 32'd1);
    step(1, 32'h0000_0393, 32'h108, OP_ADD, 1, 5, 0, 0, 0, 0); #3;
    check("lu_count", 32'(stall_count), 32'd1);
    check("lu_held_pc", ifid_pc, 32'h104);
    check("lu_after_stall", 32'(pc_stall), 32'd0);

    // false hazards and rs1/rs2 use decode; stray resume in RUN
    step(1, 32'h11, 32'h10C, OP_ADD, 0, 3, 1, 0, 0, 1);
    step(1, 32'h22, 32'h110, OP_LUI, 5, 0, 1, 5, 0, 0);
    step(1, 32'h33, 32'h114, OP_ADDI, 7, 9, 1, 7, 0, 0);
    step(1, 32'h33, 32'h114, OP_ADDI, 1, 7, 1, 7, 0, 0);
    step(1, 32'h44, 32'h118, OP_SW, 2, 9, 1, 9, 0, 0);
    step(1, 32'h44, 32'h118, OP_SW, 2, 9, 0, 0, 0, 0); #3;
    check("decode_count", 32'(stall_count), 32'd3);

    // redirect outranks a simultaneous load-use
    step(1, 32'h55, 32'h11C, OP_ADD, 5, 5, 1, 5, 1, 0); #3;
    check("redir_bubble", 32'(id_bubble), 32'd1);
    check("redir_pc_stall", 32'(pc_stall), 32'd0);
    idle(); #3;
    check("redir_ifid_valid", 32'(ifid_valid), 32'd0);
    check("redir_ifid_instr", ifid_instr, 32'h13);
    check("redir_count", 32'(stall_count), 32'd3);

    // ECALL halt: drain, halt, resume
    step(1, 32'h73, 32'h200, OP_NOP, 0, 0, 0, 0, 0, 0);
    step(1, 32'h13, 32'h204, OP_ECALL, 0, 0, 0, 0, 0, 0); #3;
    ns = pc_stall ? 1 : 0;
    saw_halt = 0;
    for (int i = 0; i < 12; i++) begin
      step(1, 32'h13, 32'h204, OP_NOP, 0, 0, (i == 1), 3, (i == 0), 0); #3;
      if (halted) begin saw_halt = 1; break; end
      if (pc_stall) ns++;
    end
    check("halt_reached", 32'(saw_halt), 32'd1);
    check("halt_stall_cycles", 32'(ns), 32'd4);
    step(1, 32'h66, 32'h204, OP_NOP, 0, 0, 0, 0, 0, 0);
    step(1, 32'h66, 32'h204, OP_NOP, 0, 0, 0, 0, 0, 1); #3;
    check("resume_cycle_halted", 32'(halted), 32'd1);
    step(1, 32'h66, 32'h204, OP_NOP, 0, 0, 0, 0, 0, 0); #3;
    check("resumed_halted", 32'(halted), 32'd0);
    check("resumed_pc_stall", 32'(pc_stall), 32'd0);
    step(1, 32'h77, 32'h208, OP_NOP, 0, 0, 0, 0, 0, 0); #3;
    check("resumed_ifid_pc", ifid_pc, 32'h204);
    check("resumed_ifid_instr", ifid_instr, 32'h66);

    // reset in the middle of DRAIN
    step(1, 32'h0010_0073, 32'h300, OP_NOP, 0, 0, 0, 0, 0, 0);
    step(1, 32'h13, 32'h304, OP_EBREAK, 0, 0, 0, 0, 0, 0);
    idle(); #3;
    check("drain_stall", 32'(pc_stall), 32'd1);
    rst_n = 0;
    idle(); #3;
    rst_n = 1;
    check("mid_rst_halted", 32'(halted), 32'd0);
    check("mid_rst_valid", 32'(ifid_valid), 32'd0);
    check("mid_rst_count", 32'(stall_count), 32'd0);
    check("mid_rst_pc_stall", 32'(pc_stall), 32'd0);

    // counter saturation
    for (int k = 0; k < CMAX + 2; k++) begin
      step(1, 32'h0050_8333, 32'(32'h400 + 4 * k), OP_ADD, 1, 5, 0, 0, 0, 0);
      step(1, 32'h0050_8333, 32'(32'h400 + 4 * k), OP_ADD, 1, 5, 1, 5, 0, 0);
    end
    idle(); #3;
    check("sat_count", 32'(stall_count), 32'(CMAX));
    idle(); idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
